// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Multi-cycle controller for the shared register-file/ALU datapath. One
//   16-bit instruction is latched on a start handshake and executed over 2-5
//   cycles by a seven-state FSM. The FSM drives operand loads, the ALU
//   operation, status capture and register write-back, then returns to WAIT
//   and raises w.
//
// Ports
//   clk      in   sole clock, rising edge
//   reset    in   synchronous, active-high
//   s        in   start request, sampled only in WAIT
//   instr    in   instruction word, latched into ir when s=1 in WAIT
//   w        out  ready, high only in WAIT
//   err      out  one-cycle pulse in DECODE on an illegal encoding
//   reg_num  out  register-file index (Rn/Rm/Rd), 0 when unused
//   write    out  register-file write strobe
//   vsel     out  write-back source: 00 = C, 10 = sximm8
//   loada    out  load A register
//   loadb    out  load B register
//   asel     out  1 forces ALU A input to 0
//   bsel     out  constant 0
//   alu_op   out  00 add, 01 sub, 10 and, 11 not-B
//   loadc    out  load result register C
//   loads    out  load status register
//   shift    out  ir[4:3]
//   sximm8   out  ir[7:0] sign-extended to 16 bits

module alu_sequencer (
   input  logic        clk,
   input  logic        reset,
   input  logic        s,
   input  logic [15:0] instr,
   output logic        w,
   output logic        err,
   output logic [2:0]  reg_num,
   output logic        write,
   output logic [1:0]  vsel,
   output logic        loada,
   output logic        loadb,
   output logic        asel,
   output logic        bsel,
   output logic [1:0]  alu_op,
   output logic        loadc,
   output logic        loads,
   output logic [1:0]  shift,
   output logic [15:0] sximm8
);

   typedef enum logic [2:0] {
      S_WAIT,
      S_DECODE,
      S_WRITE_IMM,
      S_GET_A,
      S_GET_B,
      S_EXEC,
      S_WRITE_REG
   } state_t;

   state_t      state;
   logic [15:0] ir;

   // Instruction decode works from the latched word only, so instr is free
   // to change once the instruction has been accepted.
   logic [2:0] opcode;
   logic [1:0] op;
   logic       is_mov_imm;
   logic       is_mov_reg;
   logic       is_alu;
   logic       is_cmp;
   logic       is_mvn;
   logic       legal;

   assign opcode     = ir[15:13];
   assign op         = ir[12:11];
   assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
   assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
   assign is_alu     = (opcode == 3'b101);
   assign is_cmp     = is_alu && (op == 2'b01);
   assign is_mvn     = is_alu && (op == 2'b11);
   assign legal      = is_mov_imm || is_mov_reg || is_alu;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_WAIT;
         ir    <= '0;
      end else begin
         case (state)
            S_WAIT: begin
               if (s) begin
                  ir    <= instr;
                  state <= S_DECODE;
               end
            end
            S_DECODE: begin
               if (is_mov_imm)                state <= S_WRITE_IMM;
               else if (is_mov_reg || is_mvn) state <= S_GET_B;   // single operand
               else if (is_alu)               state <= S_GET_A;   // ADD, CMP, AND
               else                           state <= S_WAIT;    // illegal
            end
            S_WRITE_IMM: state <= S_WAIT;
            S_GET_A:     state <= S_GET_B;
            S_GET_B:     state <= S_EXEC;
            S_EXEC:      state <= is_cmp ? S_WAIT : S_WRITE_REG;  // CMP only updates status
            S_WRITE_REG: state <= S_WAIT;
            default:     state <= S_WAIT;
         endcase
      end
   end

   // Datapath controls are a pure decode of state and ir.
   always_comb begin
      // NOTE: every output is given a default before the case so no path
      // leaves one unassigned, which would otherwise infer a latch.
      w       = 1'b0;
      err     = 1'b0;
      reg_num = 3'd0;
      write   = 1'b0;
      vsel    = 2'b00;
      loada   = 1'b0;
      loadb   = 1'b0;
      asel    = 1'b0;
      alu_op  = 2'b00;
      loadc   = 1'b0;
      loads   = 1'b0;
      case (state)
         S_WAIT:   w   = 1'b1;
         S_DECODE: err = !legal;
         S_WRITE_IMM: begin
            reg_num = ir[10:8];
            vsel    = 2'b10;
            write   = 1'b1;
         end
         S_GET_A: begin
            reg_num = ir[10:8];
            loada   = 1'b1;
         end
         S_GET_B: begin
            reg_num = ir[2:0];
            loadb   = 1'b1;
         end
         S_EXEC: begin
            // MOV reg is computed as 0 + shifted B; MVN ignores A as well.
            alu_op = is_mov_reg ? 2'b00 : op;
            asel   = is_mov_reg || is_mvn;
            if (is_cmp) loads = 1'b1;
            else        loadc = 1'b1;
         end
         S_WRITE_REG: begin
            reg_num = ir[7:5];
            write   = 1'b1;
         end
         default: ;
      endcase
      // An aborting reset must not let the current state commit anything on
      // the reset edge.
      if (reset) begin
         err   = 1'b0;
         write = 1'b0;
         loada = 1'b0;
         loadb = 1'b0;
         loadc = 1'b0;
         loads = 1'b0;
      end
   end

   assign bsel   = 1'b0;
   assign shift  = ir[4:3];
   assign sximm8 = {{8{ir[7]}}, ir[7:0]};

endmodule
